// File: rtl/decode_types.sv
// rtl/decode_types.sv - opcode and trap-cause constants shared by the decode stage
//
// Package decode_types
//   OP_*                 : major opcode values, i.e. instruction bits [6:2]
//   TRAP_ILLEGAL_INSTR   : trap cause reported for an illegal instruction
package decode_types;

  localparam logic [4:0] OP_LOAD     = 5'b00000;
  localparam logic [4:0] OP_MISC_MEM = 5'b00011;
  localparam logic [4:0] OP_OP_IMM   = 5'b00100;
  localparam logic [4:0] OP_AUIPC    = 5'b00101;
  localparam logic [4:0] OP_STORE    = 5'b01000;
  localparam logic [4:0] OP_OP       = 5'b01100;
  localparam logic [4:0] OP_LUI      = 5'b01101;
  localparam logic [4:0] OP_BRANCH   = 5'b11000;
  localparam logic [4:0] OP_JALR     = 5'b11001;
  localparam logic [4:0] OP_JAL      = 5'b11011;
  localparam logic [4:0] OP_SYSTEM   = 5'b11100;

  localparam logic [3:0] TRAP_ILLEGAL_INSTR = 4'd2;

endpackage

// File: rtl/instr_decoder.sv
// rtl/instr_decoder.sv - combinational field, immediate and class extraction
//
// Ports
//   instr          in   raw instruction word
//   opcode..funct7 out  instruction fields
//   *_imm          out  raw (not sign-extended) immediate bit groups
//   is_compressed  out  low two bits are not 2'b11
//   is_jump        out  BRANCH, JAL or JALR
//   is_reg_write   out  instruction class writes rd (not masked by exceptions)
//   illegal        out  compressed or unknown opcode
`ifndef ILEN
`define ILEN 32
`endif

module instr_decoder
  import decode_types::*;
(
  input  logic [`ILEN-1:0] instr,
  output logic [4:0]       opcode,
  output logic [4:0]       rd,
  output logic [2:0]       funct3,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [6:0]       funct7,
  output logic [11:0]      i_imm,
  output logic [11:0]      s_imm,
  output logic [11:0]      b_imm,
  output logic [19:0]      u_imm,
  output logic [19:0]      j_imm,
  output logic             is_compressed,
  output logic             is_jump,
  output logic             is_reg_write,
  output logic             illegal
);

  logic legal_op;

  assign opcode = instr[6:2];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  assign i_imm = instr[31:20];
  assign s_imm = {instr[31:25], instr[11:7]};
  assign b_imm = {instr[31], instr[7], instr[30:25], instr[11:8]};
  assign u_imm = instr[31:12];
  assign j_imm = {instr[31], instr[19:12], instr[20], instr[30:21]};

  assign is_compressed = (instr[1:0] != 2'b11);

  always_comb begin
    legal_op     = 1'b0;
    is_jump      = 1'b0;
    is_reg_write = 1'b0;
    case (opcode)
      OP_LOAD, OP_OP_IMM, OP_AUIPC, OP_OP, OP_LUI: begin
        legal_op     = 1'b1;
        is_reg_write = 1'b1;
      end
      OP_MISC_MEM, OP_STORE: begin
        legal_op = 1'b1;
      end
      OP_BRANCH: begin
        legal_op = 1'b1;
        is_jump  = 1'b1;
      end
      OP_JAL, OP_JALR: begin
        legal_op     = 1'b1;
        is_jump      = 1'b1;
        is_reg_write = 1'b1;
      end
      OP_SYSTEM: begin
        legal_op = 1'b1;
        // ECALL/EBREAK/xRET have funct3 == 0; CSR accesses write rd
        is_reg_write = (funct3 != 3'd0);
      end
      default: begin
        legal_op = 1'b0;
      end
    endcase
  end

  // Compressed encodings decode as illegal
  assign illegal = is_compressed || !legal_op;

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - decode pipeline register between fetch and exec
//
// Ports
//   clk, rst                          clock, asynchronous active-low reset
//   prev_stalled / stall_prev         handshake with fetch
//   fetch_*                           incoming instruction, addresses, fetch fault
//   next_stall / stall_next           handshake with exec
//   exec_pipeline_flush               flush request from exec
//   rf_rs1_sel/rf_rs2_sel, rf_rs*_data register-file read port (combinational)
//   wb_valid, wb_sel, wb_data         register-file write port, used for bypass
//   decode_*, fields, immediates      registered outputs to exec
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ILEN
`define ILEN 32
`endif
`ifndef ALEN
`define ALEN 32
`endif

module decode_stage
  import decode_types::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              prev_stalled,
  output logic              stall_prev,
  input  logic [`ILEN-1:0]  fetch_instruction,
  input  logic [`ALEN-1:0]  fetch_instruction_addr,
  input  logic [`ALEN-1:0]  fetch_instruction_next_addr,
  input  logic              fetch_exception,
  input  logic [3:0]        fetch_trap_cause,
  input  logic              next_stall,
  input  logic              exec_pipeline_flush,
  output logic [4:0]        rf_rs1_sel,
  output logic [4:0]        rf_rs2_sel,
  input  logic [`XLEN-1:0]  rf_rs1_data,
  input  logic [`XLEN-1:0]  rf_rs2_data,
  input  logic              wb_valid,
  input  logic [4:0]        wb_sel,
  input  logic [`XLEN-1:0]  wb_data,
  output logic              stall_next,
  output logic              decode_exception,
  output logic [3:0]        decode_trap_cause,
  output logic              decode_is_compressed_instr,
  output logic              decode_is_jump,
  output logic              decode_is_reg_write,
  output logic [`ILEN-1:0]  decode_instruction,
  output logic [`ALEN-1:0]  decode_instruction_addr,
  output logic [`ALEN-1:0]  decode_instruction_next_addr,
  output logic [4:0]        opcode,
  output logic [4:0]        rd,
  output logic [2:0]        funct3,
  output logic [4:0]        rs1,
  output logic [4:0]        rs2,
  output logic [6:0]        funct7,
  output logic [`XLEN-1:0]  decode_rs1_data,
  output logic [`XLEN-1:0]  decode_rs2_data,
  output logic [11:0]       i_imm,
  output logic [11:0]       s_imm,
  output logic [11:0]       b_imm,
  output logic [19:0]       u_imm,
  output logic [19:0]       j_imm
);

  logic valid;
  logic accept;

  logic [4:0]  dec_opcode, dec_rd, dec_rs1, dec_rs2;
  logic [2:0]  dec_funct3;
  logic [6:0]  dec_funct7;
  logic [11:0] dec_i_imm, dec_s_imm, dec_b_imm;
  logic [19:0] dec_u_imm, dec_j_imm;
  logic        dec_compressed, dec_jump, dec_reg_write, dec_illegal;
  logic        new_exception;
  logic [3:0]  new_cause;
  logic [`XLEN-1:0] rs1_fwd, rs2_fwd;
  logic        hold_hit1, hold_hit2;

  instr_decoder u_instr_decoder (
    .instr         (fetch_instruction),
    .opcode        (dec_opcode),
    .rd            (dec_rd),
    .funct3        (dec_funct3),
    .rs1           (dec_rs1),
    .rs2           (dec_rs2),
    .funct7        (dec_funct7),
    .i_imm         (dec_i_imm),
    .s_imm         (dec_s_imm),
    .b_imm         (dec_b_imm),
    .u_imm         (dec_u_imm),
    .j_imm         (dec_j_imm),
    .is_compressed (dec_compressed),
    .is_jump       (dec_jump),
    .is_reg_write  (dec_reg_write),
    .illegal       (dec_illegal)
  );

  assign stall_next = !valid;
  assign stall_prev = valid && next_stall;
  assign accept     = !prev_stalled && !stall_prev && !exec_pipeline_flush;

  assign rf_rs1_sel = dec_rs1;
  assign rf_rs2_sel = dec_rs2;

  // Write-through: a write landing in the accept cycle is newer than the RF read
  assign rs1_fwd = (wb_valid && wb_sel == dec_rs1 && dec_rs1 != 5'd0) ? wb_data : rf_rs1_data;
  assign rs2_fwd = (wb_valid && wb_sel == dec_rs2 && dec_rs2 != 5'd0) ? wb_data : rf_rs2_data;

  // A fetch fault outranks anything found while decoding the word
  assign new_exception = fetch_exception || dec_illegal;
  assign new_cause     = fetch_exception ? fetch_trap_cause :
                         (dec_illegal ? TRAP_ILLEGAL_INSTR : 4'd0);

  // While held, the latched sources must follow later writebacks
  assign hold_hit1 = wb_valid && wb_sel == rs1 && rs1 != 5'd0;
  assign hold_hit2 = wb_valid && wb_sel == rs2 && rs2 != 5'd0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid                        <= 1'b0;
      decode_exception             <= 1'b0;
      decode_trap_cause            <= 4'd0;
      decode_is_compressed_instr   <= 1'b0;
      decode_is_jump               <= 1'b0;
      decode_is_reg_write          <= 1'b0;
      decode_instruction           <= '0;
      decode_instruction_addr      <= '0;
      decode_instruction_next_addr <= '0;
      opcode                       <= 5'd0;
      rd                           <= 5'd0;
      funct3                       <= 3'd0;
      rs1                          <= 5'd0;
      rs2                          <= 5'd0;
      funct7                       <= 7'd0;
      decode_rs1_data              <= '0;
      decode_rs2_data              <= '0;
      i_imm                        <= 12'd0;
      s_imm                        <= 12'd0;
      b_imm                        <= 12'd0;
      u_imm                        <= 20'd0;
      j_imm                        <= 20'd0;
    end else if (exec_pipeline_flush) begin
      valid            <= 1'b0;
      decode_exception <= 1'b0;
    end else if (accept) begin
      valid                        <= 1'b1;
      decode_exception             <= new_exception;
      decode_trap_cause            <= new_cause;
      decode_is_compressed_instr   <= dec_compressed;
      decode_is_jump               <= dec_jump;
      decode_is_reg_write          <= dec_reg_write && !new_exception;
      decode_instruction           <= fetch_instruction;
      decode_instruction_addr      <= fetch_instruction_addr;
      decode_instruction_next_addr <= fetch_instruction_next_addr;
      opcode                       <= dec_opcode;
      rd                           <= dec_rd;
      funct3                       <= dec_funct3;
      rs1                          <= dec_rs1;
      rs2                          <= dec_rs2;
      funct7                       <= dec_funct7;
      decode_rs1_data              <= rs1_fwd;
      decode_rs2_data              <= rs2_fwd;
      i_imm                        <= dec_i_imm;
      s_imm                        <= dec_s_imm;
      b_imm                        <= dec_b_imm;
      u_imm                        <= dec_u_imm;
      j_imm                        <= dec_j_imm;
    end else if (valid && next_stall) begin
      if (hold_hit1) decode_rs1_data <= wb_data;
      if (hold_hit2) decode_rs2_data <= wb_data;
    end else if (valid) begin
      // consumed by exec with nothing arriving behind it
      valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage
module tb_decode_stage;

  typedef struct packed {
    logic        exc;
    logic [3:0]  cause;
    logic        comp;
    logic        jump;
    logic        regw;
    logic [31:0] instr;
    logic [31:0] addr;
    logic [31:0] naddr;
    logic [4:0]  opc;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  f7;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [11:0] i;
    logic [11:0] s;
    logic [11:0] b;
    logic [19:0] u;
    logic [19:0] j;
  } out_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        prev_stalled = 1'b1;
  logic        stall_prev;
  logic [31:0] fetch_instruction = '0;
  logic [31:0] fetch_instruction_addr = '0;
  logic [31:0] fetch_instruction_next_addr = '0;
  logic        fetch_exception = 1'b0;
  logic [3:0]  fetch_trap_cause = '0;
  logic        next_stall = 1'b0;
  logic        exec_pipeline_flush = 1'b0;
  logic [4:0]  rf_rs1_sel, rf_rs2_sel;
  logic [31:0] rf_rs1_data, rf_rs2_data;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_sel = '0;
  logic [31:0] wb_data = '0;
  logic        stall_next;
  logic        decode_exception;
  logic [3:0]  decode_trap_cause;
  logic        decode_is_compressed_instr, decode_is_jump, decode_is_reg_write;
  logic [31:0] decode_instruction, decode_instruction_addr, decode_instruction_next_addr;
  logic [4:0]  opcode, rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] decode_rs1_data, decode_rs2_data;
  logic [11:0] i_imm, s_imm, b_imm;
  logic [19:0] u_imm, j_imm;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] rf [32];
  out_t        act;
  out_t        exp_o;
  logic        exp_valid;

  int legal_ops [11] = '{'h03, 'h0F, 'h13, 'h17, 'h23, 'h33, 'h37, 'h63, 'h67, 'h6F, 'h73};
  int jump_ops  [3]  = '{'h63, 'h67, 'h6F};
  int write_ops [7]  = '{'h03, 'h13, 'h17, 'h33, 'h37, 'h67, 'h6F};

  decode_stage dut (
    .clk                          (clk),
    .rst                          (rst),
    .prev_stalled                 (prev_stalled),
    .stall_prev                   (stall_prev),
    .fetch_instruction            (fetch_instruction),
    .fetch_instruction_addr       (fetch_instruction_addr),
    .fetch_instruction_next_addr  (fetch_instruction_next_addr),
    .fetch_exception              (fetch_exception),
    .fetch_trap_cause             (fetch_trap_cause),
    .next_stall                   (next_stall),
    .exec_pipeline_flush          (exec_pipeline_flush),
    .rf_rs1_sel                   (rf_rs1_sel),
    .rf_rs2_sel                   (rf_rs2_sel),
    .rf_rs1_data                  (rf_rs1_data),
    .rf_rs2_data                  (rf_rs2_data),
    .wb_valid                     (wb_valid),
    .wb_sel                       (wb_sel),
    .wb_data                      (wb_data),
    .stall_next                   (stall_next),
    .decode_exception             (decode_exception),
    .decode_trap_cause            (decode_trap_cause),
    .decode_is_compressed_instr   (decode_is_compressed_instr),
    .decode_is_jump               (decode_is_jump),
    .decode_is_reg_write          (decode_is_reg_write),
    .decode_instruction           (decode_instruction),
    .decode_instruction_addr      (decode_instruction_addr),
    .decode_instruction_next_addr (decode_instruction_next_addr),
    .opcode                       (opcode),
    .rd                           (rd),
    .funct3                       (funct3),
    .rs1                          (rs1),
    .rs2                          (rs2),
    .funct7                       (funct7),
    .decode_rs1_data              (decode_rs1_data),
    .decode_rs2_data              (decode_rs2_data),
    .i_imm                        (i_imm),
    .s_imm                        (s_imm),
    .b_imm                        (b_imm),
    .u_imm                        (u_imm),
    .j_imm                        (j_imm)
  );

  always #5 clk = ~clk;

  assign rf_rs1_data = rf[rf_rs1_sel];
  assign rf_rs2_data = rf[rf_rs2_sel];

  always @(posedge clk) begin
    if (wb_valid && wb_sel != 5'd0) rf[wb_sel] <= wb_data;
  end

  assign act = {decode_exception, decode_trap_cause, decode_is_compressed_instr,
                decode_is_jump, decode_is_reg_write, decode_instruction,
                decode_instruction_addr, decode_instruction_next_addr, opcode, rd,
                funct3, rs1, rs2, funct7, decode_rs1_data, decode_rs2_data,
                i_imm, s_imm, b_imm, u_imm, j_imm};

  // Reference decode, written from the RISC-V field definitions
  function automatic out_t decode_ref(input logic [31:0] w, input logic [31:0] a,
                                      input logic [31:0] na, input logic fe,
                                      input logic [3:0] fc, input logic [31:0] v1,
                                      input logic [31:0] v2);
    out_t o;
    int   op7;
    int   f3;
    bit   legal, jmp, wr;
    op7 = int'(w & 32'h7C) | 3;
    f3  = int'((w >> 12) & 32'd7);
    legal = 0; jmp = 0; wr = 0;
    foreach (legal_ops[k]) if (legal_ops[k] == op7) legal = 1;
    foreach (jump_ops[k])  if (jump_ops[k] == op7)  jmp = 1;
    foreach (write_ops[k]) if (write_ops[k] == op7) wr = 1;
    if (op7 == 'h73 && f3 != 0) wr = 1;
    o.comp  = ((w & 32'd3) != 32'd3);
    o.exc   = fe || o.comp || !legal;
    o.cause = fe ? fc : (o.exc ? 4'd2 : 4'd0);
    o.jump  = jmp;
    o.regw  = wr && !o.exc;
    o.instr = w;
    o.addr  = a;
    o.naddr = na;
    o.opc   = 5'((w >> 2) & 32'd31);
    o.rd    = 5'((w >> 7) & 32'd31);
    o.f3    = 3'(f3);
    o.rs1   = 5'((w >> 15) & 32'd31);
    o.rs2   = 5'((w >> 20) & 32'd31);
    o.f7    = 7'(w >> 25);
    o.d1    = v1;
    o.d2    = v2;
    o.i     = 12'(w >> 20);
    o.s     = 12'(((w >> 25) << 5) | ((w >> 7) & 32'd31));
    o.b     = 12'((((w >> 31) & 32'd1) << 11) | (((w >> 7) & 32'd1) << 10) |
                  (((w >> 25) & 32'd63) << 4) | ((w >> 8) & 32'd15));
    o.u     = 20'(w >> 12);
    o.j     = 20'((((w >> 31) & 32'd1) << 19) | (((w >> 12) & 32'd255) << 11) |
                  (((w >> 20) & 32'd1) << 10) | ((w >> 21) & 32'd1023));
    return o;
  endfunction

  // Advance one clock, updating the reference state from the inputs now applied
  task automatic cycle();
    out_t        nx;
    logic        nv;
    int          r1, r2;
    logic [31:0] v1, v2;
    nx = exp_o;
    nv = exp_valid;
    if (exec_pipeline_flush) begin
      nv = 1'b0;
      nx.exc = 1'b0;
    end else if (!prev_stalled && !(exp_valid && next_stall)) begin
      r1 = int'((fetch_instruction >> 15) & 32'd31);
      r2 = int'((fetch_instruction >> 20) & 32'd31);
      v1 = (wb_valid && int'(wb_sel) == r1 && r1 != 0) ? wb_data : rf[r1];
      v2 = (wb_valid && int'(wb_sel) == r2 && r2 != 0) ? wb_data : rf[r2];
      nv = 1'b1;
      nx = decode_ref(fetch_instruction, fetch_instruction_addr,
                      fetch_instruction_next_addr, fetch_exception,
                      fetch_trap_cause, v1, v2);
    end else if (exp_valid && next_stall) begin
      if (wb_valid && wb_sel == exp_o.rs1 && exp_o.rs1 != 5'd0) nx.d1 = wb_data;
      if (wb_valid && wb_sel == exp_o.rs2 && exp_o.rs2 != 5'd0) nx.d2 = wb_data;
    end else if (exp_valid) begin
      nv = 1'b0;
    end
    @(posedge clk);
    #1;
    exp_o     = nx;
    exp_valid = nv;
  endtask

  task automatic present(input logic [31:0] w);
    fetch_instruction           = w;
    fetch_instruction_addr      = $urandom & 32'hFFFF_FFFC;
    fetch_instruction_next_addr = fetch_instruction_addr + 32'd4;
    fetch_exception             = 1'b0;
    fetch_trap_cause            = 4'd0;
    prev_stalled                = 1'b0;
  endtask

  task automatic idle();
    prev_stalled        = 1'b1;
    next_stall          = 1'b0;
    exec_pipeline_flush = 1'b0;
    wb_valid            = 1'b0;
    fetch_exception     = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    exp_o = '0;
    exp_valid = 1'b0;
    n_checks++;
    if (stall_next !== 1'b1) begin n_fail++; $display("FAIL reset_stall_next: got %b expected 1", stall_next); end
    n_checks++;
    if (stall_prev !== 1'b0) begin n_fail++; $display("FAIL reset_stall_prev: got %b expected 0", stall_prev); end
    n_checks++;
    if (act !== out_t'(0)) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", act); end
    rst = 1'b1;
    cycle();
    n_checks++;
    if (stall_next !== 1'b1) begin n_fail++; $display("FAIL reset_release_idle: got %b expected 1", stall_next); end
  endtask

  task automatic test_addi();
    present(32'h0050_0093);
    next_stall = 1'b0;
    cycle();
    idle();
    n_checks++;
    if (stall_next !== 1'b0) begin n_fail++; $display("FAIL addi_stall_next: got %b expected 0", stall_next); end
    n_checks++;
    if (opcode !== 5'b00100 || rd !== 5'd1 || i_imm !== 12'h005)
      begin n_fail++; $display("FAIL addi_fields: got op=%b rd=%0d imm=%h expected op=00100 rd=1 imm=005", opcode, rd, i_imm); end
    n_checks++;
    if (decode_is_reg_write !== 1'b1 || decode_is_jump !== 1'b0)
      begin n_fail++; $display("FAIL addi_flags: got wr=%b jmp=%b expected wr=1 jmp=0", decode_is_reg_write, decode_is_jump); end
    n_checks++;
    if (act !== exp_o) begin n_fail++; $display("FAIL addi_model: got %h expected %h", act, exp_o); end
    cycle();
    n_checks++;
    if (stall_next !== 1'b1) begin n_fail++; $display("FAIL addi_consumed: got %b expected 1", stall_next); end
  endtask

  task automatic test_hold_refresh();
    present(32'h0050_8113);  // addi x2,x1,5
    next_stall = 1'b1;
    cycle();
    present(32'h0030_0193);  // must not be taken while holding
    for (int c = 0; c < 3; c++) begin
      wb_valid = (c == 1);
      wb_sel   = 5'd1;
      wb_data  = 32'hDEAD_BEEF;
      #1;
      n_checks++;
      if (stall_prev !== 1'b1) begin n_fail++; $display("FAIL hold_stall_prev c%0d: got %b expected 1", c, stall_prev); end
      cycle();
      n_checks++;
      if (act !== exp_o || stall_next !== 1'b0)
        begin n_fail++; $display("FAIL hold_outputs c%0d: got %h sn=%b expected %h sn=0", c, act, stall_next, exp_o); end
    end
    n_checks++;
    if (decode_rs1_data !== 32'hDEAD_BEEF)
      begin n_fail++; $display("FAIL hold_refresh_rs1: got %h expected deadbeef", decode_rs1_data); end
    idle();
    cycle();
  endtask

  task automatic test_exceptions();
    logic [31:0] words [4] = '{32'h0000_0000, 32'h0050_0093, 32'h0000_007F, 32'h0000_007F};
    logic        fexc  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [3:0]  want  [4] = '{4'd2, 4'd1, 4'd2, 4'd1};
    for (int k = 0; k < 4; k++) begin
      present(words[k]);
      fetch_exception  = fexc[k];
      fetch_trap_cause = fexc[k] ? 4'd1 : 4'd0;
      next_stall = 1'b0;
      cycle();
      idle();
      n_checks++;
      if (decode_exception !== 1'b1 || decode_trap_cause !== want[k] || decode_is_reg_write !== 1'b0)
        begin n_fail++; $display("FAIL exc_%0d: got exc=%b cause=%0d wr=%b expected exc=1 cause=%0d wr=0", k, decode_exception, decode_trap_cause, decode_is_reg_write, want[k]); end
      n_checks++;
      if (act !== exp_o) begin n_fail++; $display("FAIL exc_model_%0d: got %h expected %h", k, act, exp_o); end
    end
    n_checks++;
    if (decode_is_compressed_instr !== 1'b0)
      begin n_fail++; $display("FAIL exc_not_compressed: got %b expected 0", decode_is_compressed_instr); end
    present(32'h0000_0000);
    cycle();
    idle();
    n_checks++;
    if (decode_is_compressed_instr !== 1'b1)
      begin n_fail++; $display("FAIL exc_compressed: got %b expected 1", decode_is_compressed_instr); end
    cycle();
  endtask

  task automatic test_back_to_back();
    present(32'h0080_00EF);  // jal x1,8
    next_stall = 1'b0;
    cycle();
    n_checks++;
    if (stall_next !== 1'b0 || decode_is_jump !== 1'b1 || j_imm !== 20'h00004)
      begin n_fail++; $display("FAIL b2b_jal: got sn=%b jmp=%b j_imm=%h expected sn=0 jmp=1 j_imm=00004", stall_next, decode_is_jump, j_imm); end
    present(32'h0000_0463);  // beq x0,x0,8
    cycle();
    idle();
    n_checks++;
    if (stall_next !== 1'b0 || decode_is_jump !== 1'b1 || decode_instruction !== 32'h0000_0463)
      begin n_fail++; $display("FAIL b2b_beq: got sn=%b jmp=%b instr=%h expected sn=0 jmp=1 instr=00000463", stall_next, decode_is_jump, decode_instruction); end
    n_checks++;
    if (act !== exp_o) begin n_fail++; $display("FAIL b2b_model: got %h expected %h", act, exp_o); end
    cycle();
  endtask

  task automatic test_flush();
    present(32'h0000_0000);
    next_stall = 1'b1;
    cycle();
    present(32'h0050_0093);
    exec_pipeline_flush = 1'b1;
    cycle();
    n_checks++;
    if (stall_next !== 1'b1 || decode_exception !== 1'b0)
      begin n_fail++; $display("FAIL flush_hold: got sn=%b exc=%b expected sn=1 exc=0", stall_next, decode_exception); end
    next_stall = 1'b0;
    present(32'h0000_007F);
    exec_pipeline_flush = 1'b1;
    cycle();
    n_checks++;
    if (stall_next !== 1'b1 || decode_exception !== 1'b0)
      begin n_fail++; $display("FAIL flush_accept: got sn=%b exc=%b expected sn=1 exc=0", stall_next, decode_exception); end
    exec_pipeline_flush = 1'b0;
    cycle();
    idle();
    n_checks++;
    if (stall_next !== 1'b0 || act !== exp_o)
      begin n_fail++; $display("FAIL flush_represent: got sn=%b %h expected sn=0 %h", stall_next, act, exp_o); end
    cycle();
  endtask

  task automatic test_random();
    logic [31:0] w;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 9) < 8) w = ($urandom & 32'hFFFF_FF80) | 32'(legal_ops[$urandom_range(0, 10)]);
      else w = $urandom;
      present(w);
      prev_stalled        = ($urandom_range(0, 9) < 3);
      next_stall          = ($urandom_range(0, 9) < 4);
      exec_pipeline_flush = ($urandom_range(0, 19) == 0);
      fetch_exception     = ($urandom_range(0, 9) == 0);
      fetch_trap_cause    = 4'($urandom);
      wb_valid            = ($urandom_range(0, 1) == 1);
      wb_sel              = ($urandom_range(0, 1) == 1) ? exp_o.rs1 : 5'($urandom);
      wb_data             = $urandom;
      #1;
      n_checks++;
      if (stall_prev !== (exp_valid && next_stall) || rf_rs1_sel !== 5'((w >> 15) & 32'd31) || rf_rs2_sel !== 5'((w >> 20) & 32'd31))
        begin n_fail++; $display("FAIL rand_comb c%0d: got sp=%b sel=%0d/%0d expected sp=%b", c, stall_prev, rf_rs1_sel, rf_rs2_sel, exp_valid && next_stall); end
      cycle();
      n_checks++;
      if (stall_next !== !exp_valid || act !== exp_o)
        begin n_fail++; $display("FAIL rand_out c%0d: got sn=%b %h expected sn=%b %h", c, stall_next, act, !exp_valid, exp_o); end
    end
    idle();
    cycle();
  endtask

  task automatic test_async_reset();
    present(32'h0050_8113);
    next_stall = 1'b1;
    cycle();
    prev_stalled = 1'b1;
    cycle();
    #3;
    rst = 1'b0;
    #1;
    exp_o = '0;
    exp_valid = 1'b0;
    n_checks++;
    if (stall_next !== 1'b1 || stall_prev !== 1'b0 || act !== out_t'(0))
      begin n_fail++; $display("FAIL async_reset: got sn=%b sp=%b %h expected sn=1 sp=0 all zero", stall_next, stall_prev, act); end
    #2;
    rst = 1'b1;
    idle();
    next_stall = 1'b1;
    cycle();
    cycle();
    n_checks++;
    if (stall_next !== 1'b1 || act !== out_t'(0))
      begin n_fail++; $display("FAIL async_reset_no_reappear: got sn=%b %h expected sn=1 all zero", stall_next, act); end
  endtask

  initial begin
    foreach (rf[k]) rf[k] = (k == 0) ? 32'd0 : $urandom;
    exp_o = '0;
    exp_valid = 1'b0;
    test_reset();
    test_addi();
    test_hold_refresh();
    test_exceptions();
    test_back_to_back();
    test_flush();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
